muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It executes MULT, MULTU, DIV and DIVU over several cycles, instead of producing a 64-bit product combinationally in the ALU. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. The block sits beside the ALU and is sourced from the register-file read ports; the controller stalls on `busy`.

## Interface

Parameters:

- `WIDTH`, 32: operand and HI/LO width; must be even and ≥ 4.

Ports:

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `srca`  in  WIDTH  multiplicand/dividend; also the MTHI/MTLO data.
- `srcb`  in  WIDTH  multiplier/divisor.
- `hiwrite`  in  1  MTHI: HI ← `srca`.
- `lowrite`  in  1  MTLO: LO ← `srca`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `divzero`  out  1  valid with `done`; the completed divide had `srcb` = 0.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

- FSM states:
  - IDLE, RUN.
  - IDLE → RUN when `start`=1.
  - RUN → IDLE when the iteration counter reaches WIDTH−1.
- At the start edge:
  - `op`, `srca` and `srcb` are latched.
  - For signed ops the operands are converted to magnitudes; the result-sign flags are latched.
  - Input changes during RUN have no effect.
- Multiply:
  - Radix-2 shift-add, one multiplier bit per cycle, WIDTH iterations.
  - The 2·WIDTH-bit product {HI,LO} is sign-corrected if the operand signs differ.
- Divide:
  - Restoring divide, one quotient bit per cycle, WIDTH iterations.
  - LO = quotient; HI = remainder.
  - Signed divide: quotient sign = sign(a) XOR sign(b); remainder sign = sign of dividend (truncating division).
- Divide by zero (`srcb`=0, DIV or DIVU): HI = latched `srca` unchanged, LO = all ones, `divzero`=1 with `done`. Latency is the same as a normal divide.
- Signed overflow: DIV of the most-negative value by −1 gives LO = most-negative value, HI = 0, `divzero`=0.
- HI/LO are written only at completion; during RUN they keep their previous values, so MFHI/MFLO see the old contents.
- MTHI/MTLO:
  - In IDLE, `hiwrite`/`lowrite` update HI/LO at the next edge; both may be asserted together.
  - In RUN they are ignored and the write is dropped; the controller must stall them.
- `start` and `hiwrite`/`lowrite` in the same IDLE cycle: `start` wins and the writes are dropped.
- `start` during RUN is ignored.
- `op` values are all legal; no invalid-op state exists.

## Timing

- Reset (async, immediate): state IDLE, counter 0, `busy`=0, `done`=0, `divzero`=0, `hi`=0, `lo`=0.
- `start` sampled at edge E0:
  - `busy`=1 from E0 through edge E(WIDTH).
  - At E(WIDTH), HI/LO are updated, `busy`=0 and `done`=1 for exactly one cycle.
  - `busy` is high for WIDTH cycles. Result latency: WIDTH cycles from the start edge.
- `done`, `divzero` and `busy` are registered outputs with no combinational input-to-output paths.
- A new `start` is accepted in the `done` cycle (back-to-back operations, no bubble).
- `divzero` clears on the next edge with `done`.
- Reset asserted mid-operation aborts it: no `done`, HI/LO = 0.
- After reset deasserts, the block is IDLE and accepts `start` on the first edge.

## Test plan

- MULT, WIDTH=32, `srca`=0xFFFFFFFD (−3), `srcb`=5 → after 32 busy cycles `done` pulse, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. MULTU 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 → `lo`=3, `hi`=1. Repeat with WIDTH=8: DIV 0xF9/0x02 → `lo`=0xFD, `hi`=0xFF, `busy` high for 8 cycles.
- DIV 0x00001234/0 → `hi`=0x00001234, `lo`=0xFFFFFFFF, `divzero`=1 in the `done` cycle only. DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `divzero`=0.
- MTHI 0xAAAA5555 and MTLO 0x12345678 in IDLE → `hi`/`lo` updated next edge.
- Start MULTU 3×4:
  - Mid-run, pulse `hiwrite` and re-pulse `start`, and change `srca`/`srcb` → all ignored. `hi`/`lo` keep the MTHI/MTLO values until `done`, then become 0 and 12.
- Back-to-back ops and reset:
  - Start DIVU in the `done` cycle → accepted, `busy` without a gap.
  - Assert `reset` at busy cycle 10 → immediately `busy`=0, `hi`=`lo`=0, and no `done` follows.

Source files
------------

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the architectural HI/LO registers.
// One multiplier or quotient bit per cycle; HI/LO change only at completion or on MTHI/MTLO.
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hiwrite,
    input  logic             lowrite,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;
    logic [WIDTH-1:0] srca_q;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        a_neg = ~op[0] & srca[WIDTH-1];
        b_neg = ~op[0] & srcb[WIDTH-1];
        abs_a = a_neg ? -srca : srca;
        abs_b = b_neg ? -srcb : srcb;
    end

    // One iteration: multiply keeps {upper, multiplier} as a 2W shift register,
    // divide keeps {remainder, dividend/quotient} and shifts left.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   step_hi;
    logic [WIDTH-1:0]   step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, operand};
        div_rem   = div_shift[WIDTH-1:0] - operand;
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            step_hi = div_ge ? div_rem : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_q ? -prod : prod;
        res_hi   = prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = prod_fix[WIDTH-1:0];
        if (is_div) begin
            if (dz_q) begin
                res_hi = srca_q;
                res_lo = '1;
            end else begin
                res_hi = neg_r ? -step_hi : step_hi;
                res_lo = neg_q ? -step_lo : step_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            srca_q  <= '0;
            operand <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state   <= RUN;
                    busy    <= 1'b1;
                    count   <= '0;
                    is_div  <= op[1];
                    neg_q   <= a_neg ^ b_neg;
                    neg_r   <= a_neg;
                    dz_q    <= (srcb == '0);
                    srca_q  <= srca;
                    acc_hi  <= '0;
                    operand <= op[1] ? abs_b : abs_a;
                    acc_lo  <= op[1] ? abs_a : abs_b;
                end else begin
                    // MTHI/MTLO are only honoured when no operation is being launched.
                    if (hiwrite) hi <= srca;
                    if (lowrite) lo <= srca;
                end
            end else begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                count  <= count + CW'(1);
                if (count == LAST) begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    divzero <= is_div & dz_q;
                    hi      <= res_hi;
                    lo      <= res_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed and random checks of muldiv_hilo at WIDTH=32 and WIDTH=8.
// Expected {divzero, hi, lo} is queued at launch and popped on the done pulse.
module tb_muldiv_hilo;

    logic clk = 1'b0;
    logic reset;

    logic        start32, hiwrite32, lowrite32;
    logic [1:0]  op32;
    logic [31:0] srca32, srcb32;
    logic        busy32, done32, divzero32;
    logic [31:0] hi32, lo32;

    logic        start8, hiwrite8, lowrite8;
    logic [1:0]  op8;
    logic [7:0]  srca8, srcb8;
    logic        busy8, done8, divzero8;
    logic [7:0]  hi8, lo8;

    logic [64:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    muldiv_hilo #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32),
        .srca(srca32), .srcb(srcb32), .hiwrite(hiwrite32), .lowrite(lowrite32),
        .busy(busy32), .done(done32), .divzero(divzero32), .hi(hi32), .lo(lo32)
    );

    muldiv_hilo #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .op(op8),
        .srca(srca8), .srcb(srcb8), .hiwrite(hiwrite8), .lowrite(lowrite8),
        .busy(busy8), .done(done8), .divzero(divzero8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cur_hilo(input bit n);
        return n ? {24'd0, hi8, 24'd0, lo8} : {hi32, lo32};
    endfunction

    function automatic logic get_done(input bit n);
        return n ? done8 : done32;
    endfunction

    function automatic logic get_busy(input bit n);
        return n ? busy8 : busy32;
    endfunction

    function automatic logic get_dz(input bit n);
        return n ? divzero8 : divzero32;
    endfunction

    function automatic longint sx(input int w, input logic [31:0] v, input bit sgn);
        logic [63:0] u;
        u = 64'(v) & ((64'd1 << w) - 64'd1);
        if (sgn && u[w-1]) return longint'(u) - longint'(64'd1 << w);
        return longint'(u);
    endfunction

    // Reference model: {divzero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m, pu, hu, lu;
        longint sa, sb, p, q, r;
        bit sgn;
        m   = (64'd1 << w) - 64'd1;
        sgn = !op[0];
        sa  = sx(w, a, sgn);
        sb  = sx(w, b, sgn);
        if (!op[1]) begin
            p  = sa * sb;
            pu = p;
            return {1'b0, 32'((pu >> w) & m), 32'(pu & m)};
        end
        if ((64'(b) & m) == 64'd0) return {1'b1, 32'(64'(a) & m), 32'(m)};
        if (sgn && sb == -1 && sa == -(longint'(1) << (w - 1)))
            return {1'b0, 32'd0, 32'(64'(a) & m)};
        q  = sa / sb;
        r  = sa % sb;
        hu = r;
        lu = q;
        return {1'b0, 32'(hu & m), 32'(lu & m)};
    endfunction

    // Called just after a falling edge; returns 1 time unit after the start edge.
    task automatic launch(input bit n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (n) begin
            op8 = op; srca8 = a[7:0]; srcb8 = b[7:0]; start8 = 1'b1;
        end else begin
            op32 = op; srca32 = a; srcb32 = b; start32 = 1'b1;
        end
        @(posedge clk);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
        srca8   = 8'($urandom);
        srcb8   = 8'($urandom);
        srca32  = $urandom;
        srcb32  = $urandom;
    endtask

    task automatic wait_done(input bit n, input int disturb_at, input bit post);
        int w;
        int busy_cnt;
        bit seen;
        bit held;
        logic [63:0] old;
        logic [64:0] e;
        w = n ? 8 : 32;
        busy_cnt = 0;
        seen = 1'b0;
        held = 1'b1;
        old = cur_hilo(n);
        for (int i = 0; i < w + 8 && !seen; i++) begin
            @(negedge clk);
            if (get_done(n)) begin
                seen = 1'b1;
            end else begin
                if (get_busy(n)) busy_cnt++;
                if (cur_hilo(n) !== old) held = 1'b0;
                if (disturb_at != 0 && busy_cnt == disturb_at) begin
                    start32 = 1'b1; hiwrite32 = 1'b1; lowrite32 = 1'b1;
                    srca32 = $urandom; srcb32 = $urandom; op32 = 2'($urandom_range(0, 3));
                end else if (disturb_at != 0 && busy_cnt == disturb_at + 1) begin
                    start32 = 1'b0; hiwrite32 = 1'b0; lowrite32 = 1'b0;
                end
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("busy_cycles", 64'(busy_cnt), 64'(w));
        chk("hilo_held_during_run", 64'(held), 64'd1);
        chk("busy_low_at_done", 64'(get_busy(n)), 64'd0);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
            chk("hilo_result", cur_hilo(n), e[63:0]);
            chk("divzero_at_done", 64'(get_dz(n)), 64'(e[64]));
        end
        if (post) begin
            @(negedge clk);
            chk("done_one_cycle", 64'(get_done(n)), 64'd0);
            chk("divzero_clears", 64'(get_dz(n)), 64'd0);
        end
    endtask

    task automatic run_exp(input bit n, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [64:0] e);
        exp_q.push_back(e);
        launch(n, op, a, b);
        wait_done(n, 0, 1'b1);
    endtask

    task automatic run_model(input bit n, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        run_exp(n, op, a, b, model(n ? 8 : 32, op, a, b));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        reset = 1'b1;
        start32 = 1'b0; hiwrite32 = 1'b0; lowrite32 = 1'b0; op32 = 2'd0; srca32 = '0; srcb32 = '0;
        start8 = 1'b0; hiwrite8 = 1'b0; lowrite8 = 1'b0; op8 = 2'd0; srca8 = '0; srcb8 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 64'(busy32), 64'd0);
        chk("reset_done", 64'(done32), 64'd0);
        chk("reset_divzero", 64'(divzero32), 64'd0);
        chk("reset_hilo", cur_hilo(1'b0), 64'd0);
        chk("reset_hilo8", cur_hilo(1'b1), 64'd0);
        reset = 1'b0;

        // MTHI and MTLO together, then separately
        hiwrite32 = 1'b1; lowrite32 = 1'b1; srca32 = 32'h0F0F_0F0F;
        @(negedge clk);
        chk("mthi_mtlo_both", cur_hilo(1'b0), 64'h0F0F0F0F_0F0F0F0F);
        lowrite32 = 1'b0; srca32 = 32'hAAAA_5555;
        @(negedge clk);
        chk("mthi", cur_hilo(1'b0), 64'hAAAA5555_0F0F0F0F);
        hiwrite32 = 1'b0; lowrite32 = 1'b1; srca32 = 32'h1234_5678;
        @(negedge clk);
        chk("mtlo", cur_hilo(1'b0), 64'hAAAA5555_12345678);
        lowrite32 = 1'b0;

        // MULTU 3x4 with MTHI in the start cycle and a mid-run disturbance
        exp_q.push_back({1'b0, 32'd0, 32'd12});
        hiwrite32 = 1'b1;
        launch(1'b0, 2'b01, 32'd3, 32'd4);
        hiwrite32 = 1'b0;
        chk("start_beats_mthi", cur_hilo(1'b0), 64'hAAAA5555_12345678);
        wait_done(1'b0, 5, 1'b1);

        run_exp(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd5, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1});
        run_exp(1'b0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {1'b0, 32'hFFFF_FFFE, 32'h0000_0001});
        run_exp(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2, {1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_exp(1'b0, 2'b11, 32'd7, 32'd2, {1'b0, 32'd1, 32'd3});
        run_exp(1'b0, 2'b10, 32'h0000_1234, 32'd0, {1'b1, 32'h0000_1234, 32'hFFFF_FFFF});
        run_exp(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {1'b0, 32'd0, 32'h8000_0000});

        // Back-to-back: next DIVU launched in the done cycle
        exp_q.push_back(model(32, 2'b11, 32'd1000, 32'd7));
        launch(1'b0, 2'b11, 32'd1000, 32'd7);
        wait_done(1'b0, 0, 1'b0);
        exp_q.push_back(model(32, 2'b11, 32'hFFFF_FFFF, 32'h10));
        launch(1'b0, 2'b11, 32'hFFFF_FFFF, 32'h10);
        chk("b2b_busy_no_gap", 64'(busy32), 64'd1);
        wait_done(1'b0, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            run_model(1'b0, rop, ra, rb);
        end

        // Reset in the middle of a multiply, then restart on the first edge
        launch(1'b0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_done", 64'(done32), 64'd0);
        chk("abort_hilo", cur_hilo(1'b0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(model(32, 2'b11, 32'd100, 32'd7));
        launch(1'b0, 2'b11, 32'd100, 32'd7);
        wait_done(1'b0, 0, 1'b1);

        // WIDTH=8 instance
        run_exp(1'b1, 2'b10, 32'hF9, 32'h02, {1'b0, 32'hFF, 32'hFD});
        run_exp(1'b1, 2'b10, 32'h80, 32'hFF, {1'b0, 32'h00, 32'h80});
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 32'($urandom_range(0, 255));
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom_range(0, 255));
            run_model(1'b1, rop, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
